// File: rtl/spike_syn_decoder.sv
// Spike-to-number decoder: turns a neuron's 1-bit spike level into a decaying
// synaptic trace and a windowed spike-event rate with a one-cycle valid strobe.
module spike_syn_decoder #(
    parameter int unsigned WINDOW      = 16,
    parameter logic [7:0]  WEIGHT      = 8'd16,
    parameter int unsigned DECAY_SHIFT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       spike_in,
    output logic [7:0] syn_current,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic       sat_flag
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TRACE_W = DATA_W + 1;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0]   WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [TRACE_W-1:0] TRACE_MAX = TRACE_W'(255);

    logic               spike_prev;
    logic               evt;
    logic [CNT_W-1:0]   window_cnt;
    logic [DATA_W-1:0]  spike_cnt;
    logic [DATA_W-1:0]  cnt_inc;
    logic [DATA_W-1:0]  leak;
    logic [TRACE_W-1:0] trace_sum;

    // Rising-edge event, saturating count and 9-bit leaky-integrator sum
    always_comb begin
        evt       = spike_in & ~spike_prev;
        cnt_inc   = (spike_cnt == 8'hFF) ? 8'hFF : spike_cnt + DATA_W'(evt);
        leak      = syn_current >> DECAY_SHIFT;
        trace_sum = TRACE_W'(syn_current) - TRACE_W'(leak)
                  + (evt ? TRACE_W'(WEIGHT) : TRACE_W'(0));
    end

    // Edge detector tracks the input regardless of en, so edges during pause are lost
    always_ff @(posedge clk) begin
        if (!rst_n) spike_prev <= 1'b0;
        else        spike_prev <= spike_in;
    end

    // Synaptic trace with saturation and sticky flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syn_current <= '0;
            sat_flag    <= 1'b0;
        end else if (en) begin
            if (trace_sum > TRACE_MAX) begin
                syn_current <= 8'hFF;
                sat_flag    <= 1'b1;
            end else begin
                syn_current <= trace_sum[DATA_W-1:0];
            end
        end
    end

    // Window counter; the closing cycle's event belongs to the closing window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_cnt <= '0;
            spike_cnt  <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (en) begin
                if (window_cnt == WIN_LAST) begin
                    rate       <= cnt_inc;
                    rate_valid <= 1'b1;
                    spike_cnt  <= '0;
                    window_cnt <= '0;
                end else begin
                    window_cnt <= window_cnt + CNT_W'(1);
                    spike_cnt  <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_syn_decoder.sv
// Directed self-checking bench for spike_syn_decoder; a second instance with a
// large weight exercises trace saturation.
module tb_spike_syn_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       spike_in;
    logic [7:0] syn_current, rate, syn_current_w, rate_w;
    logic       rate_valid, sat_flag, rate_valid_w, sat_flag_w;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    spike_syn_decoder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .syn_current(syn_current), .rate(rate),
        .rate_valid(rate_valid), .sat_flag(sat_flag)
    );

    spike_syn_decoder #(.WINDOW(16), .WEIGHT(8'd200), .DECAY_SHIFT(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
        .syn_current(syn_current_w), .rate(rate_w),
        .rate_valid(rate_valid_w), .sat_flag(sat_flag_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        spike_in = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int exp_decay [11] = '{16, 14, 13, 12, 11, 10, 9, 8, 7, 7, 7};
    int peak;
    int pulses;
    int bad;

    initial begin
        rst_n = 1'b0; en = 1'b1; spike_in = 1'b0;

        // Reset with spike_in toggling
        for (int i = 0; i < 3; i++) begin
            spike_in = ~spike_in;
            tick();
        end
        check("rst_syn", syn_current, 0);
        check("rst_rate", rate, 0);
        check("rst_valid", rate_valid, 0);
        check("rst_sat", sat_flag, 0);
        rst_n = 1'b1; spike_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rate_valid !== 1'b0 || syn_current !== 8'd0) bad++;
        end
        check("idle_no_early_valid", bad, 0);
        tick();
        check("first_valid", rate_valid, 1);
        check("first_rate", rate, 0);

        // Single-cycle spike decay profile
        do_reset();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        check("decay_0", syn_current, exp_decay[0]);
        for (int i = 1; i < 11; i++) begin
            tick();
            check($sformatf("decay_%0d", i), syn_current, exp_decay[i]);
        end
        for (int i = 0; i < 4; i++) tick();
        check("decay_pre_close", rate_valid, 0);
        tick();
        check("decay_close_valid", rate_valid, 1);
        check("decay_close_rate", rate, 1);
        check("decay_hold", syn_current, 7);

        // Held spike is one event
        do_reset();
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            spike_in = (i < 5);
            tick();
            if (int'(syn_current) > peak) peak = int'(syn_current);
            if (i == 14) check("held_pre_close", rate_valid, 0);
        end
        check("held_valid", rate_valid, 1);
        check("held_rate", rate, 1);
        check("held_peak", peak, 16);

        // Alternating spikes over two windows
        do_reset();
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            spike_in = (i % 2 == 0);
            tick();
            if (rate_valid) begin
                pulses++;
                check($sformatf("alt_rate_t%0d", i), rate, 8);
                check($sformatf("alt_when_t%0d", i), i % 16, 15);
            end
        end
        check("alt_pulses", pulses, 2);

        // Saturation on the heavy-weight instance
        do_reset();
        spike_in = 1'b1; tick();
        check("sat_step0", syn_current_w, 200);
        spike_in = 1'b0; tick();
        check("sat_step1", syn_current_w, 175);
        check("sat_flag_pre", sat_flag_w, 0);
        spike_in = 1'b1; tick();
        check("sat_step2", syn_current_w, 255);
        check("sat_flag_set", sat_flag_w, 1);
        check("sat_light_inst", sat_flag, 0);
        spike_in = 1'b0; tick();
        check("sat_decay", syn_current_w, 224);
        for (int i = 0; i < 10; i++) tick();
        check("sat_sticky", sat_flag_w, 1);

        // Pause mid-window: delay by 5, lost edge, count preserved
        do_reset();
        spike_in = 1'b1; tick();
        spike_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pause_syn_before", syn_current, 12);
        en = 1'b0; spike_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rate_valid !== 1'b0 || syn_current !== 8'd12) bad++;
        end
        check("pause_frozen", bad, 0);
        en = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        spike_in = 1'b0;
        check("pause_pre_close", rate_valid, 0);
        tick();
        check("pause_close_valid", rate_valid, 1);
        check("pause_close_rate", rate, 1);

        // Mid-window reset at window_cnt == 8
        spike_in = 1'b1; tick();
        spike_in = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0; tick();
        check("midrst_valid", rate_valid, 0);
        check("midrst_rate", rate, 0);
        check("midrst_syn", syn_current, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rate_valid !== 1'b0) bad++;
        end
        check("midrst_no_early", bad, 0);
        tick();
        check("midrst_new_valid", rate_valid, 1);
        check("midrst_new_rate", rate, 0);
        tick();
        check("valid_one_cycle", rate_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
